sd_block_responder: RTL and testbench

SD_BLOCK_RESPONDER -- requirements
Module: sd_block_responder

---
 rtl/sd_block_responder.sv | 154 +++++++++++++++
 tb/tb_sd_block_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_responder.sv
// Streams 512-byte sectors between a byte-wide store (1-cycle read) and the core SD buffer; 513 cycles ack-rise to last strobe.
// Build option SD_RESPONDER_WRITE_EN: when defined, write transfers update the store; otherwise the image is forced read-only.
module sd_block_responder #(
  parameter int LBA_BITS = 6
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [31:0]           sd_lba,
  input  logic                  sd_rd,
  input  logic                  sd_wr,
  output logic                  sd_ack,
  output logic [8:0]            sd_buff_addr,
  output logic [7:0]            sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [7:0]            sd_buff_din,
  output logic [LBA_BITS+8:0]   store_addr,
  output logic                  store_we,
  output logic [7:0]            store_d,
  input  logic [7:0]            store_q,
  input  logic                  mount,
  input  logic                  present,
  input  logic                  readonly_in,
  output logic                  img_mounted,
  output logic                  img_readonly,
  output logic [63:0]           img_size,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, XFER_RD, XFER_WR, DONE} state_t;

  localparam logic [63:0] IMG_BYTES = 64'd1 << (LBA_BITS + 9);
`ifdef SD_RESPONDER_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
`endif

  state_t                state_q;
  logic [LBA_BITS-1:0]   lba_q;
  logic                  oob_q;
  logic [9:0]            cnt_q;
  logic                  p1_vld_q;
  logic [8:0]            p1_n_q;
  logic                  mount_pend_q;
  logic                  sd_ack_q, sd_buff_wr_q, store_we_q, img_mounted_q, img_readonly_q, err_q;
  logic [8:0]            sd_buff_addr_q;
  logic [7:0]            sd_buff_dout_q, store_d_q;
  logic [LBA_BITS+8:0]   store_addr_q;
  logic [63:0]           img_size_q;

  logic                  oob_d, mount_d, wr_ok_d;
  logic [8:0]            next_n_d;

  always_comb begin
    oob_d    = |sd_lba[31:LBA_BITS];
    mount_d  = mount | mount_pend_q;
    wr_ok_d  = WR_EN & ~oob_q & ~img_readonly_q;
    next_n_d = cnt_q[8:0] + 9'd1;
  end

  // cnt_q issues sector offsets; p1 carries each offset one cycle later, when store_q / sd_buff_din are valid.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= IDLE;
      lba_q          <= '0;
      oob_q          <= 1'b0;
      cnt_q          <= '0;
      p1_vld_q       <= 1'b0;
      p1_n_q         <= '0;
      mount_pend_q   <= 1'b0;
      sd_ack_q       <= 1'b0;
      sd_buff_wr_q   <= 1'b0;
      store_we_q     <= 1'b0;
      img_mounted_q  <= 1'b0;
      img_readonly_q <= 1'b0;
      err_q          <= 1'b0;
      sd_buff_addr_q <= '0;
      sd_buff_dout_q <= '0;
      store_d_q      <= '0;
      store_addr_q   <= '0;
      img_size_q     <= '0;
    end else begin
      sd_buff_wr_q  <= 1'b0;
      store_we_q    <= 1'b0;
      img_mounted_q <= 1'b0;
      p1_vld_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mount_d) begin
            mount_pend_q   <= 1'b0;
            img_mounted_q  <= 1'b1;
            img_readonly_q <= readonly_in | ~WR_EN;
            img_size_q     <= present ? IMG_BYTES : 64'd0;
            err_q          <= 1'b0;
          end
          if (sd_rd | sd_wr) begin
            state_q        <= sd_rd ? XFER_RD : XFER_WR;
            lba_q          <= sd_lba[LBA_BITS-1:0];
            oob_q          <= oob_d;
            if (oob_d) err_q <= 1'b1;
            cnt_q          <= '0;
            sd_ack_q       <= 1'b1;
            sd_buff_addr_q <= '0;
            store_addr_q   <= {sd_lba[LBA_BITS-1:0], 9'd0};
          end
        end
        XFER_RD, XFER_WR: begin
          if (mount) mount_pend_q <= 1'b1;
          if (!cnt_q[9]) begin
            cnt_q    <= cnt_q + 10'd1;
            p1_vld_q <= 1'b1;
            p1_n_q   <= cnt_q[8:0];
            if (cnt_q[8:0] != 9'd511) begin
              if (state_q == XFER_RD) store_addr_q   <= {lba_q, next_n_d};
              else                    sd_buff_addr_q <= next_n_d;
            end
          end
          if (p1_vld_q) begin
            if (state_q == XFER_RD) begin
              sd_buff_wr_q   <= 1'b1;
              sd_buff_addr_q <= p1_n_q;
              sd_buff_dout_q <= oob_q ? 8'hFF : store_q;
            end else begin
              store_we_q   <= wr_ok_d;
              store_addr_q <= {lba_q, p1_n_q};
              store_d_q    <= sd_buff_din;
            end
          end else if (cnt_q[9]) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (mount) mount_pend_q <= 1'b1;
          sd_ack_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd_ack       = sd_ack_q;
  assign sd_buff_addr = sd_buff_addr_q;
  assign sd_buff_dout = sd_buff_dout_q;
  assign sd_buff_wr   = sd_buff_wr_q;
  assign store_addr   = store_addr_q;
  assign store_we     = store_we_q;
  assign store_d      = store_d_q;
  assign img_mounted  = img_mounted_q;
  assign img_readonly = img_readonly_q;
  assign img_size     = img_size_q;
  assign err          = err_q;
  assign busy         = (state_q != IDLE) | mount_pend_q;
endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: transfer vector table plus mount, reset and deferral sequences.
module tb_sd_block_responder;
`ifdef SD_RESPONDER_WRITE_EN
  localparam bit WR_BUILD = 1'b1;
`else
  localparam bit WR_BUILD = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] sd_lba = '0;
  logic        sd_rd = 1'b0, sd_wr = 1'b0;
  logic        sd_ack, sd_buff_wr, store_we, img_mounted, img_readonly, busy, err;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, store_d;
  logic [7:0]  sd_buff_din = '0;
  logic [7:0]  store_q = '0;
  logic [14:0] store_addr;
  logic        mount = 1'b0, present = 1'b0, readonly_in = 1'b0;
  logic [63:0] img_size;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  sd_block_responder #(.LBA_BITS(6)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .store_addr(store_addr),
    .store_we(store_we), .store_d(store_d), .store_q(store_q), .mount(mount),
    .present(present), .readonly_in(readonly_in), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size(img_size), .busy(busy), .err(err)
  );

  // Backing store: unwritten bytes read as addr[7:0]^8'h5A. Core buffer byte n is n[7:0].
  logic [7:0] mem [0:32767];
  bit         wvld [0:32767];
  always @(posedge clk_sys) begin
    if (store_we) begin
      mem[store_addr]  <= store_d;
      wvld[store_addr] <= 1'b1;
    end
    store_q     <= wvld[store_addr] ? mem[store_addr] : (store_addr[7:0] ^ 8'h5A);
    sd_buff_din <= sd_buff_addr[7:0];
  end

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [31:0] lba, input int n);
    logic [7:0] nb;
    nb = n[7:0];
    if ((lba >> 6) != 32'd0) return 8'hFF;
    return nb ^ 8'h5A;
  endfunction

  task automatic do_mount(input logic pres, input logic ro);
    present = pres; readonly_in = ro; mount = 1'b1;
    @(negedge clk_sys);
    mount = 1'b0;
  endtask

  task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] lba,
                         output int ack_cyc, output int n_strobe, output int n_we,
                         output int n_bad, output int lat);
    int  first_ack, last_strb;
    bit  seen;
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    ack_cyc = 0; n_strobe = 0; n_we = 0; n_bad = 0;
    first_ack = -1; last_strb = -1; seen = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk_sys);
      if (sd_ack) begin
        if (!seen) first_ack = c;
        seen = 1'b1; ack_cyc++; sd_rd = 1'b0; sd_wr = 1'b0;
      end
      if (sd_buff_wr) begin
        if (sd_buff_addr != n_strobe[8:0] || sd_buff_dout != exp_rd(lba, n_strobe)) n_bad++;
        n_strobe++; last_strb = c;
      end
      if (store_we) n_we++;
      if (seen && !sd_ack) break;
    end
    sd_rd = 1'b0; sd_wr = 1'b0;
    lat = last_strb - first_ack;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    int          ack;
    int          strobes;
    int          we;
    logic        err;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int ack_cyc, n_strobe, n_we, n_bad, lat, cnt;
    bit hit, seen, mdone;
    logic [7:0] expb;

    vecs[0] = '{1'b1, 1'b0, 32'd3,          515, 512, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'd0,          515, 512, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'd10,         515, 512, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'd63,         515, 0, WR_BUILD ? 512 : 0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'd64,         515, 512, 0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_0000,  515, 512, 0, 1'b1};

    repeat (2) @(negedge clk_sys);
    check("rst_ack", int'(sd_ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_img_size", int'(img_size[31:0]), 0);
    check("rst_readonly", int'(img_readonly), 0);
    check("rst_buff_addr", int'(sd_buff_addr), 0);
    reset = 1'b0;
    @(negedge clk_sys);

    do_mount(1'b1, 1'b0);
    check("mnt_pulse", int'(img_mounted), 1);
    check("mnt_size", int'(img_size[31:0]), 32768);
    check("mnt_readonly", int'(img_readonly), WR_BUILD ? 0 : 1);
    @(negedge clk_sys);
    check("mnt_pulse_end", int'(img_mounted), 0);

    for (int i = 0; i < 6; i++) begin
      do_xfer(vecs[i].rd, vecs[i].wr, vecs[i].lba, ack_cyc, n_strobe, n_we, n_bad, lat);
      check($sformatf("v%0d_ack_cycles", i), ack_cyc, vecs[i].ack);
      check($sformatf("v%0d_strobes", i), n_strobe, vecs[i].strobes);
      check($sformatf("v%0d_store_we", i), n_we, vecs[i].we);
      check($sformatf("v%0d_bad_bytes", i), n_bad, 0);
      check($sformatf("v%0d_err", i), int'(err), int'(vecs[i].err));
      if (vecs[i].rd) check($sformatf("v%0d_latency", i), lat, 513);
    end

    cnt = 0;
    for (int n = 0; n < 512; n++) begin
      expb = WR_BUILD ? n[7:0] : (n[7:0] ^ 8'h5A);
      if ((wvld[63*512+n] ? mem[63*512+n] : (n[7:0] ^ 8'h5A)) != expb) cnt++;
    end
    check("wr63_store_bad", cnt, 0);

    do_mount(1'b1, 1'b0);
    check("err_cleared", int'(err), 0);
    @(negedge clk_sys);

    do_mount(1'b1, 1'b1);
    check("ro_readonly", int'(img_readonly), 1);
    @(negedge clk_sys);
    do_xfer(1'b0, 1'b1, 32'd5, ack_cyc, n_strobe, n_we, n_bad, lat);
    check("ro_ack_cycles", ack_cyc, 515);
    check("ro_store_we", n_we, 0);

    sd_lba = 32'd2; sd_rd = 1'b1; hit = 1'b0;
    for (int c = 0; c < 800 && !hit; c++) begin
      @(negedge clk_sys);
      if (sd_ack) sd_rd = 1'b0;
      if (sd_buff_wr && sd_buff_addr == 9'd100) hit = 1'b1;
    end
    check("rst_mid_reached", int'(hit), 1);
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst_mid_ack", int'(sd_ack), 0);
    check("rst_mid_strobe", int'(sd_buff_wr), 0);
    check("rst_mid_store_addr", int'(store_addr), 0);
    check("rst_mid_dout", int'(sd_buff_dout), 0);
    check("rst_mid_busy", int'(busy), 0);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (sd_buff_wr || store_we || sd_ack) cnt++;
    end
    check("rst_mid_quiet", cnt, 0);
    do_xfer(1'b1, 1'b0, 32'd7, ack_cyc, n_strobe, n_we, n_bad, lat);
    check("post_rst_ack", ack_cyc, 515);
    check("post_rst_strobes", n_strobe, 512);
    check("post_rst_bad", n_bad, 0);

    sd_lba = 32'd9; sd_rd = 1'b1; seen = 1'b0; mdone = 1'b0; cnt = 0; ack_cyc = 0; n_bad = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk_sys);
      mount = 1'b0;
      if (sd_ack) begin
        seen = 1'b1; ack_cyc++; sd_rd = 1'b0;
        if (!busy) n_bad++;
      end
      if (img_mounted) cnt++;
      if (ack_cyc == 50 && !mdone) begin
        mdone = 1'b1; present = 1'b0; readonly_in = 1'b0; mount = 1'b1;
      end
      if (seen && !sd_ack) break;
    end
    mount = 1'b0;
    check("defer_no_early_pulse", cnt, 0);
    check("defer_busy_in_xfer", n_bad, 0);
    check("defer_idle_mounted", int'(img_mounted), 0);
    check("defer_idle_busy", int'(busy), 1);
    @(negedge clk_sys);
    check("defer_pulse", int'(img_mounted), 1);
    check("defer_size_absent", int'(img_size[31:0]), 0);
    check("defer_busy_clear", int'(busy), 0);
    @(negedge clk_sys);
    check("defer_pulse_end", int'(img_mounted), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end
endmodule
